// File: rtl/prod_accum_pkg.sv
// Shared types and defaults for the product accumulator.
// Holds the FSM state encoding and the default widths.
package prod_accum_pkg;

   localparam int P_W_DEF   = 8;
   localparam int ACC_W_DEF = 12;
   localparam int CNT_W     = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   // A length of 0 requests the full 16 products.
   function automatic logic [CNT_W-1:0] len_to_cnt(
      input logic [3:0] len
   );
      logic [CNT_W-1:0] r;
      if (len == 4'd0) r = CNT_W'(16);
      else             r = {1'b0, len};
      return r;
   endfunction

endpackage

// File: rtl/prod_cnt.sv
// Remaining-product down-counter with load and zero detect.
// last flags the decrement that takes the count to zero.
import prod_accum_pkg::*;

module prod_cnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_len,
   input  logic       dec,
   output logic       last
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = len_to_cnt(load_len);
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   assign last = dec && (cnt_q == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/prod_accum.sv
// Accumulates a programmed number of multiplier products and
// presents the sum with a valid/ready handshake.
import prod_accum_pkg::*;

module prod_accum #(
   parameter int P_W   = P_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       len,
   input  logic             p_valid,
   input  logic [P_W-1:0]   p_data,
   output logic             p_ready,
   output logic [ACC_W-1:0] sum,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic             busy
);

   state_e           state_q;
   state_e           state_d;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic             cnt_load;
   logic             cnt_last;
   logic             xfer;

   assign p_ready = (state_q == ACCUM);
   assign xfer    = p_valid && p_ready;

   prod_cnt u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_len (len),
      .dec      (xfer),
      .last     (cnt_last)
   );

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = ACCUM;
               acc_d    = '0;
               cnt_load = 1'b1;
            end
         end
         ACCUM: begin
            if (xfer) begin
               acc_d = acc_q + ACC_W'(p_data);
               if (cnt_last) state_d = DONE;
            end
         end
         DONE: begin
            if (sum_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
      end
   end

   // The accumulator doubles as the result register.
   assign sum       = acc_q;
   assign sum_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: directed scenarios plus random traffic
// checked every cycle against a behavioural job model.
module tb_prod_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  len;
   logic        p_valid;
   logic [7:0]  p_data;
   logic        p_ready;
   logic [11:0] sum;
   logic        sum_valid;
   logic        sum_ready;
   logic        busy;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   // Model: phase 0 idle, 1 collecting, 2 holding result.
   int m_phase = 0;
   int m_sum = 0;
   int m_rem = 0;

   logic [7:0] dat [16];

   prod_accum dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .p_valid   (p_valid),
      .p_data    (p_data),
      .p_ready   (p_ready),
      .sum       (sum),
      .sum_valid (sum_valid),
      .sum_ready (sum_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t",
                  name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase = 0;
         m_sum   = 0;
         m_rem   = 0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_phase = 1;
            m_sum   = 0;
            m_rem   = (len == 0) ? 16 : int'(len);
         end
      end else if (m_phase == 1) begin
         if (p_valid) begin
            m_sum = m_sum + int'(p_data);
            m_rem = m_rem - 1;
            if (m_rem == 0) m_phase = 2;
         end
      end else begin
         if (sum_ready) m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_p_ready", int'(p_ready), int'(m_phase == 1));
         chk("cyc_busy", int'(busy), int'(m_phase != 0));
         chk("cyc_sum_valid", int'(sum_valid), int'(m_phase == 2));
         chk("cyc_sum", int'(sum), m_sum);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One job: n products, gap stall cycles between them,
   // hold cycles in DONE with a start pulse before release.
   task automatic job(input int l, input int gap,
                      input int hold, input int exp);
      int n;
      n = (l == 0) ? 16 : l;
      start = 1'b1;
      len   = 4'(l);
      tick();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         p_valid = 1'b1;
         p_data  = dat[i];
         chk("job_p_ready", int'(p_ready), 1);
         tick();
         p_valid = 1'b0;
         if (i < n - 1) begin
            for (int g = 0; g < gap; g++) begin
               chk("stall_p_ready", int'(p_ready), 1);
               tick();
            end
         end
      end
      chk("job_valid_after_last", int'(sum_valid), 1);
      chk("job_sum", int'(sum), exp);
      chk("model_sum", m_sum, exp);
      for (int h = 0; h < hold; h++) begin
         start = (h == 1);
         len   = 4'd2;
         tick();
      end
      start = 1'b0;
      chk("hold_valid", int'(sum_valid), 1);
      chk("hold_sum", int'(sum), exp);
      sum_ready = 1'b1;
      tick();
      sum_ready = 1'b0;
      chk("release_busy", int'(busy), 0);
      chk("release_valid", int'(sum_valid), 0);
      chk("idle_sum_held", int'(sum), exp);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      len       = 4'd0;
      p_valid   = 1'b0;
      p_data    = 8'd0;
      sum_ready = 1'b0;
      tick();
      tick();
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      chk("rst_p_ready", int'(p_ready), 0);
      chk("rst_sum", int'(sum), 0);
      chk("rst_sum_valid", int'(sum_valid), 0);
      chk("rst_busy", int'(busy), 0);

      dat[0] = 8'd1; dat[1] = 8'd4;
      dat[2] = 8'd9; dat[3] = 8'd16;
      job(4, 0, 0, 30);

      for (int i = 0; i < 16; i++) dat[i] = 8'hFF;
      job(0, 0, 0, 4080);

      dat[0] = 8'd15; dat[1] = 8'd50; dat[2] = 8'd196;
      job(3, 2, 5, 261);

      // Abort a job halfway with reset.
      dat[0] = 8'd7; dat[1] = 8'd9;
      start = 1'b1;
      len   = 4'd4;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         p_valid = 1'b1;
         p_data  = dat[i];
         tick();
      end
      p_valid = 1'b0;
      rst_n   = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_p_ready", int'(p_ready), 0);
      chk("abort_sum", int'(sum), 0);
      chk("abort_sum_valid", int'(sum_valid), 0);
      chk("abort_busy", int'(busy), 0);
      dat[0] = 8'd64;
      job(1, 0, 0, 64);

      // Random traffic, including stray starts and rare resets.
      for (int c = 0; c < 4000; c++) begin
         start     = ($urandom_range(3) == 0);
         len       = 4'($urandom);
         p_valid   = ($urandom_range(2) != 0);
         p_data    = 8'($urandom);
         sum_ready = ($urandom_range(2) == 0);
         rst_n     = ($urandom_range(299) != 0);
         tick();
      end
      start     = 1'b0;
      p_valid   = 1'b0;
      sum_ready = 1'b1;
      rst_n     = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      cmp_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
